// File: rtl/pipelined_barrel_shifter_pkg.sv
// barrel_shifter_pkg: shared types for the pipelined barrel shifter.
// Shift modes, per-stage control bundle and stage-count helper.
package barrel_shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_ROR
  } shift_op_t;

  // Control that travels with every beat; amt residue and tag ride
  // alongside as parameter-sized vectors.
  typedef struct packed {
    logic      valid;
    shift_op_t op;
  } stage_ctl_t;

  function automatic int stage_count(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: valid/ready operand and result channels.
// slave = shifter side, master = source/consumer side.
// BARREL_SHIFTER_ZERO_FLAG_EN adds out_zero.
interface pipelined_barrel_shifter_if
  import barrel_shifter_pkg::*;
#(
  parameter int N     = 32,
  parameter int AMT_W = 8,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic [AMT_W-1:0] in_amt;
  shift_op_t        in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
  logic             out_zero;
`endif

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_tag,
    input  out_ready,
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    output out_zero,
`endif
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_data, in_amt, in_op, in_tag,
    output out_ready,
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    input  out_zero,
`endif
    input  in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// shift_stage: one conditional 2^K shift/rotate plus pipeline register.
// Ports: en (advance), src_* bundle in, dst_* registered bundle out.
module shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int N     = 32,
  parameter int TAG_W = 4,
  parameter int K     = 0,
  parameter int S     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  stage_ctl_t       src_ctl,
  input  logic [S-1:0]     src_amt,
  input  logic [TAG_W-1:0] src_tag,
  input  logic [N-1:0]     src_data,
  output stage_ctl_t       dst_ctl,
  output logic [S-1:0]     dst_amt,
  output logic [TAG_W-1:0] dst_tag,
  output logic [N-1:0]     dst_data
);

  localparam int SH = 1 << K;

  logic [N-1:0] shifted;

  always_comb begin
    shifted = src_data;
    if (src_amt[K]) begin
      unique case (src_ctl.op)
        OP_SLL: shifted = src_data << SH;
        OP_SRL: shifted = src_data >> SH;
        OP_SRA: shifted = N'($signed(src_data) >>> SH);
        OP_ROR: shifted = (src_data >> SH)
                        | (src_data << (N - SH));
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dst_ctl  <= '0;
      dst_amt  <= '0;
      dst_tag  <= '0;
      dst_data <= '0;
    end else if (en) begin
      dst_ctl  <= src_ctl;
      dst_amt  <= src_amt;
      dst_tag  <= src_tag;
      dst_data <= shifted;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: S=$clog2(N) shift stages plus output register.
// Ports: clk, rst_n (sync, active-low), bus (slave modport).
// BARREL_SHIFTER_ZERO_FLAG_EN adds registered out_zero.
module pipelined_barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int N     = 32,
  parameter int AMT_W = 8,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst_n,
  pipelined_barrel_shifter_if.slave bus
);

  localparam int S = stage_count(N);

  logic advance;
  logic big;

  stage_ctl_t   e_ctl;
  logic [S-1:0] e_amt;
  logic [N-1:0] e_data;

  stage_ctl_t       q_ctl  [S];
  logic [S-1:0]     q_amt  [S];
  logic [TAG_W-1:0] q_tag  [S];
  logic [N-1:0]     q_data [S];

  logic             ov;
  logic [N-1:0]     od;
  logic [TAG_W-1:0] ot;

  assign advance      = ~(ov & ~bus.out_ready);
  assign bus.in_ready = advance;
  assign big          = |(bus.in_amt >> S);

  // Out-of-range amounts are folded into the data at entry so the
  // stages only ever see an S-bit residue.
  always_comb begin
    e_ctl  = '{valid: bus.in_valid, op: bus.in_op};
    e_amt  = bus.in_amt[S-1:0];
    e_data = bus.in_data;
    unique case (1'b1)
      big && (bus.in_op inside {OP_SLL, OP_SRL}): begin
        e_amt  = '0;
        e_data = '0;
      end
      big && (bus.in_op == OP_SRA): begin
        e_amt  = '0;
        e_data = {N{bus.in_data[N-1]}};
      end
      default: ;
    endcase
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    if (k == 0) begin : g_first
      shift_stage #(.N(N), .TAG_W(TAG_W), .K(k), .S(S)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (advance),
        .src_ctl  (e_ctl),
        .src_amt  (e_amt),
        .src_tag  (bus.in_tag),
        .src_data (e_data),
        .dst_ctl  (q_ctl[k]),
        .dst_amt  (q_amt[k]),
        .dst_tag  (q_tag[k]),
        .dst_data (q_data[k])
      );
    end else begin : g_rest
      shift_stage #(.N(N), .TAG_W(TAG_W), .K(k), .S(S)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (advance),
        .src_ctl  (q_ctl[k-1]),
        .src_amt  (q_amt[k-1]),
        .src_tag  (q_tag[k-1]),
        .src_data (q_data[k-1]),
        .dst_ctl  (q_ctl[k]),
        .dst_amt  (q_amt[k]),
        .dst_tag  (q_tag[k]),
        .dst_data (q_data[k])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ov <= 1'b0;
      od <= '0;
      ot <= '0;
    end else if (advance) begin
      ov <= q_ctl[S-1].valid;
      od <= q_data[S-1];
      ot <= q_tag[S-1];
    end
  end

`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
  logic oz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oz <= 1'b0;
    end else if (advance) begin
      oz <= (q_data[S-1] == '0);
    end
  end

  assign bus.out_zero = oz;
`endif

  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign bus.out_tag   = ot;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed + scoreboard bench, N=32.
// Define BARREL_SHIFTER_ZERO_FLAG_EN to also check out_zero.
module tb_pipelined_barrel_shifter;
  import barrel_shifter_pkg::*;

  localparam int N     = 32;
  localparam int AMT_W = 8;
  localparam int TAG_W = 4;
  localparam int S     = 5;

  typedef struct {
    logic [N-1:0]     d;
    logic [TAG_W-1:0] t;
    int               c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(
    .N(N), .AMT_W(AMT_W), .TAG_W(TAG_W)
  ) bus ();

  pipelined_barrel_shifter #(
    .N(N), .AMT_W(AMT_W), .TAG_W(TAG_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           emitted = 0;
  int           acc_n = 0;
  bit           chk_lat = 1'b1;
  logic [N-1:0] cur_exp = '0;

  function automatic logic [N-1:0] model(
    logic [N-1:0] d, logic [AMT_W-1:0] a, shift_op_t op);
    int r;
    case (op)
      OP_SLL: return (a >= N) ? '0 : d << a;
      OP_SRL: return (a >= N) ? '0 : d >> a;
      OP_SRA: return (a >= N) ? {N{d[N-1]}}
                              : N'($signed(d) >>> a);
      default: begin
        r = int'(a) % N;
        return (r == 0) ? d : ((d >> r) | (d << (N - r)));
      end
    endcase
  endfunction

  task automatic chk(string tag, logic [N-1:0] got,
                     logic [N-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard bookkeeping for the beats that transfer on the coming
  // edge, then advance one cycle and settle past the edge.
  task automatic tick();
    exp_t e;
    if (rst_n && bus.in_valid && bus.in_ready) begin
      sb.push_back('{d: cur_exp, t: bus.in_tag, c: cyc});
      acc_n++;
    end
    if (rst_n && bus.out_valid && bus.out_ready) begin
      emitted++;
      if (sb.size() == 0) begin
        chk("extra_beat", bus.out_data, 'x);
      end else begin
        e = sb.pop_front();
        chk("data", bus.out_data, e.d);
        chk("tag", N'(bus.out_tag), N'(e.t));
        if (chk_lat) chk("latency", N'(cyc - e.c - 1), N'(S));
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
        chk("zero", N'(bus.out_zero), N'(e.d == '0));
`endif
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(logic [N-1:0] d, logic [AMT_W-1:0] a,
                       shift_op_t op, logic [TAG_W-1:0] t,
                       logic [N-1:0] x);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_op    = op;
    bus.in_tag   = t;
    cur_exp      = x;
  endtask

  task automatic send(logic [N-1:0] d, logic [AMT_W-1:0] a,
                      shift_op_t op, logic [TAG_W-1:0] t,
                      logic [N-1:0] x, output int n);
    bit took;
    took = 1'b0;
    n = 0;
    drive(d, a, op, t, x);
    for (int i = 0; i < 50 && !took; i++) begin
      took = bus.in_ready;
      tick();
      n++;
    end
    chk("accept", N'(took), N'(1));
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) tick();
    chk("drain", N'(sb.size()), '0);
  endtask

  task automatic one(logic [N-1:0] d, logic [AMT_W-1:0] a,
                     shift_op_t op, logic [TAG_W-1:0] t,
                     logic [N-1:0] x);
    int n;
    send(d, a, op, t, x, n);
    idle();
    drain();
  endtask

  initial begin
    int n;
    int e0;
    logic [N-1:0] d;
    logic [AMT_W-1:0] a;
    shift_op_t op;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = OP_SLL;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    tick();
    tick();
    chk("rst_valid", N'(bus.out_valid), '0);
    chk("rst_data", bus.out_data, '0);
    chk("rst_tag", N'(bus.out_tag), '0);
`ifdef BARREL_SHIFTER_ZERO_FLAG_EN
    chk("rst_zero", N'(bus.out_zero), '0);
`endif
    rst_n = 1'b1;
    tick();
    chk("rst_ready", N'(bus.in_ready), N'(1));

    one(32'h8000_0000, 8'd4, OP_SRA, 4'h3, 32'hF800_0000);
    one(32'h0000_0001, 8'd1, OP_ROR, 4'h1, 32'h8000_0000);
    one(32'h0000_0001, 8'd33, OP_ROR, 4'h2, 32'h8000_0000);
    one(32'h0000_0001, 8'd32, OP_ROR, 4'h4, 32'h0000_0001);
    one(32'hFFFF_FFFF, 8'd40, OP_SLL, 4'h5, 32'h0000_0000);
    one(32'hFFFF_FFFF, 8'd31, OP_SRL, 4'h6, 32'h0000_0001);
    one(32'h7FFF_FFFF, 8'd200, OP_SRA, 4'h7, 32'h0000_0000);
    one(32'h8000_0000, 8'd255, OP_SRA, 4'h8, 32'hFFFF_FFFF);
    one(32'h8000_0000, 8'd0, OP_SRA, 4'h9, 32'h8000_0000);
    one(32'h1234_5678, 8'd8, OP_ROR, 4'hA, 32'h7812_3456);
    one(32'h0000_0001, 8'd32, OP_SLL, 4'hB, 32'h0000_0000);
    one(32'h0000_0001, 8'd31, OP_SLL, 4'hC, 32'h8000_0000);

    // Ten back-to-back ops: each must be taken on its first cycle.
    for (int i = 0; i < 10; i++) begin
      d  = $urandom;
      a  = AMT_W'($urandom_range(0, 63));
      op = shift_op_t'($urandom_range(0, 3));
      send(d, a, op, TAG_W'(i), model(d, a, op), n);
      chk("b2b_one_cycle", N'(n), N'(1));
    end
    idle();
    drain();

    // Backpressure: hold the consumer off for three cycles while a
    // new beat is offered, then release and drain.
    chk_lat = 1'b0;
    e0 = emitted - acc_n;
    for (int i = 0; i < 6; i++) begin
      d  = $urandom;
      a  = AMT_W'($urandom_range(0, 40));
      op = shift_op_t'($urandom_range(0, 3));
      send(d, a, op, TAG_W'(i + 3), model(d, a, op), n);
    end
    idle();
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    chk("stall_seen", N'(bus.out_valid), N'(1));
    bus.out_ready = 1'b0;
    drive(32'h0000_00F0, 8'd4, OP_SRL, 4'hE, 32'h0000_000F);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_ready", N'(bus.in_ready), '0);
      chk("stall_valid", N'(bus.out_valid), N'(1));
      chk("stall_data", bus.out_data, sb[0].d);
      chk("stall_tag", N'(bus.out_tag), N'(sb[0].t));
    end
    bus.out_ready = 1'b1;
    send(32'h0000_00F0, 8'd4, OP_SRL, 4'hE, 32'h0000_000F, n);
    idle();
    drain();
    chk("no_loss", N'(emitted - acc_n), N'(e0));
    chk_lat = 1'b1;

    // Reset with three beats in flight discards them all.
    for (int i = 0; i < 3; i++) begin
      send(32'hDEAD_BEEF, AMT_W'(i), OP_SLL, 4'hD,
           model(32'hDEAD_BEEF, AMT_W'(i), OP_SLL), n);
    end
    idle();
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", N'(bus.out_valid), '0);
    chk("midrst_data", bus.out_data, '0);
    chk("midrst_tag", N'(bus.out_tag), '0);
    rst_n = 1'b1;
    sb.delete();
    chk("midrst_ready", N'(bus.in_ready), N'(1));
    for (int i = 0; i < S; i++) begin
      tick();
      chk("midrst_quiet", N'(bus.out_valid), '0);
    end
    one(32'h0000_0001, 8'd4, OP_SLL, 4'h2, 32'h0000_0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter with valid/ready handshake, four shift/rotate modes and a pass-through tag.
- Next generation of the combinational N-bit shifter: one registered stage per shift-amount bit, so wide datapaths (N=32/64) meet timing.
- Sits between an operand source and an ALU-style consumer; any N that is a power of two ≥ 4.

Parameters:
- N, 32, data width; power of two, ≥ 4.
- AMT_W, 8, shift-amount port width; must satisfy AMT_W ≥ $clog2(N).
- TAG_W, 4, width of sideband tag carried alongside each operation.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept the input this cycle.
- in_data  in  N  operand.
- in_amt  in  AMT_W  shift amount, unsigned.
- in_op  in  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  sideband; returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  N  shifted result.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Transfer occurs on a rising edge with valid & ready high on the same side.
- S = $clog2(N) stages. Stage k shifts or rotates by 2^k when amt bit k = 1.
- Latency: a beat accepted at edge t appears at out_valid after edge t+S (5 cycles for N=32). Throughput is 1 op/cycle with no backpressure.
- Stall = out_valid & ~out_ready. advance = ~stall. in_ready = advance (combinational from out_ready and out_valid).
  - On stall, every stage register holds.
  - Bubbles are not collapsed.
- Out-of-range amounts are evaluated at entry:
  - in_amt ≥ N for SLL/SRL: result 0.
  - in_amt ≥ N for SRA: all bits = in_data[N-1].
  - ROR uses in_amt mod N, i.e. the low S bits.
  - in_amt = 0: result = in_data for all modes.
- Fill rules: SLL and SRL zero-fill. SRA fills with the sign bit. ROR wraps bit 0 to bit N-1.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_tag hold stable.
- Reset:
  - rst_n=0 sampled at an edge clears all stage valid bits, out_valid, out_data and out_tag to 0.
  - in_ready reads 1 in the cycle after reset deasserts.
  - Reset mid-stream discards all in-flight operations. No partial results are emitted.
- Simultaneous accept and emit in one cycle is legal and expected in steady state.
- in_valid while in_ready=0: the beat is not taken. The source must hold it (AXI-style).
- No internal state machine beyond per-stage valid bits. The pipeline behaves as an S-deep shift register of {valid, data, amt residue, op, tag}.

Optional Feature:
- Macro: BARREL_SHIFTER_ZERO_FLAG_EN.
- Defined: adds output port out_zero (1 bit), = (out_data == 0), registered alongside out_data. Same latency, hold and reset rules; reset value 0.
- Undefined: the port is absent and no extra logic is built.

Decomposition:
- Package barrel_shifter_pkg holds:
  - typedef enum logic [1:0] shift_op_t {OP_SLL, OP_SRL, OP_SRA, OP_ROR};
  - function clog2-based stage count helper.
  - packed struct template fields: valid, op, amt residue, tag.
- Sub-module shift_stage, parameterised by N, TAG_W and stage index K:
  - one conditional 2^K shift/rotate plus its pipeline register and enable;
  - top-level instantiates S copies in a generate loop.

Test Plan:
- N=32, SRA, data 0x80000000, amt 4 -> out_data 0xF8000000, out_valid exactly 5 cycles after accept; tag 0x3 returns 0x3.
- N=32, ROR, data 0x00000001, amt 1 -> 0x80000000. Same with amt 33 -> 0x80000000. amt 32 -> 0x00000001.
- N=32, SLL, data 0xFFFFFFFF, amt 40 -> 0x00000000. SRL amt 31 -> 0x00000001. SRA of 0x7FFFFFFF amt 200 -> 0x00000000.
- Back-to-back 10 ops with out_ready=1 -> 10 consecutive out_valid cycles, results in order. Then hold out_ready=0 for 3 cycles -> in_ready=0, out_data/out_tag unchanged, no beats lost or duplicated after release.
- Three ops in flight, assert rst_n=0 for 1 cycle -> out_valid stays 0 for the following S cycles; no stale result emitted; next accepted op completes normally.
- With BARREL_SHIFTER_ZERO_FLAG_EN: SLL 0x00000001 by 32 -> out_zero=1. SLL by 31 -> out_data 0x80000000, out_zero=0.
